board_render_ctrl: RTL and testbench

Per-pixel scheduler for the 2048 board renderer. It shares one `display_number` glyph path across the 16 board tiles. From the VGA scan coordinates it works out which tile, if any, the pixel falls in, then drives `display_number` with that tile's value, coordinates and tile origin. A double-buffered board snapshot with a valid/ready handshake keeps each frame visually consistent while game logic updates the board.

---
 rtl/game_2048_pkg.sv | 27 ++
 rtl/tile_locator.sv | 65 ++++++
 rtl/board_render_ctrl.sv | 145 ++++++++++++++
 tb/tb_board_render_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 board renderer.
// Holds default board geometry, the tile value type, the scheduler state enum
// and the legal-tile-value check used by the renderer.
package game_2048_pkg;

  localparam int BOARD_X_DEF  = 105;
  localparam int BOARD_Y_DEF  = 25;
  localparam int TILE_DEF     = 100;
  localparam int GAP_DEF      = 10;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [11:0] tile_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Legal tile values are 0 (empty) and the powers of two 2..2048.
  // A 12-bit value is a power of two iff exactly one bit is set; 1 is excluded.
  function automatic logic is_legal(input tile_t v);
    tile_t vm1;
    vm1 = v - 12'd1;
    return (v == 12'd0) || ((v != 12'd1) && ((v & vm1) == 12'd0));
  endfunction

endpackage

// File: rtl/tile_locator.sv
// Purpose: maps scan coordinates onto the 4x4 tile grid using comparisons only.
// Latency: purely combinational.
// Backpressure: none; it has no handshake.
// Ports: x, y scan position in; row, col, in_tile, x_org, y_org out.
// x_org/y_org/row/col are forced to 0 whenever the pixel is outside every tile.
module tile_locator
  import game_2048_pkg::*;
#(
  parameter int BOARD_X = BOARD_X_DEF,
  parameter int BOARD_Y = BOARD_Y_DEF,
  parameter int TILE    = TILE_DEF,
  parameter int GAP     = GAP_DEF
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       in_tile,
  output logic [9:0] x_org,
  output logic [9:0] y_org
);

  localparam int PITCH = TILE + GAP;

  // Left/top edge of each column/row, fixed at elaboration time.
  logic [9:0] col_lo [4];
  logic [9:0] row_lo [4];

  for (genvar g = 0; g < 4; g++) begin : g_edges
    assign col_lo[g] = 10'(BOARD_X + g * PITCH);
    assign row_lo[g] = 10'(BOARD_Y + g * PITCH);
  end

  logic       col_hit, row_hit;
  logic [1:0] col_c, row_c;
  logic [9:0] x_org_c, y_org_c;

  always_comb begin
    col_hit = 1'b0;
    row_hit = 1'b0;
    col_c   = 2'd0;
    row_c   = 2'd0;
    x_org_c = 10'd0;
    y_org_c = 10'd0;
    for (int c = 0; c < 4; c++) begin
      if ((x >= col_lo[c]) && (x < col_lo[c] + 10'(TILE))) begin
        col_hit = 1'b1;
        col_c   = 2'(c);
        x_org_c = col_lo[c];
      end
      if ((y >= row_lo[c]) && (y < row_lo[c] + 10'(TILE))) begin
        row_hit = 1'b1;
        row_c   = 2'(c);
        y_org_c = row_lo[c];
      end
    end
  end

  assign in_tile = col_hit & row_hit;
  assign row     = in_tile ? row_c   : 2'd0;
  assign col     = in_tile ? col_c   : 2'd0;
  assign x_org   = in_tile ? x_org_c : 10'd0;
  assign y_org   = in_tile ? y_org_c : 10'd0;

endmodule

// File: rtl/board_render_ctrl.sv
// Purpose: per-pixel scheduler sharing one display_number path across 16 tiles.
// Latency: 1 cycle; every output is registered from the current cycle's inputs.
// Backpressure: board_ready low while the pending snapshot is full; sender holds data.
// Ports: clk, rst (sync active-low); x, y, video_on, hsync_in, vsync_in scan inputs;
//   board_in/board_valid/board_ready snapshot handshake; number, px_x, px_y,
//   x_offset, y_offset, active_pixel, tile_idx, hsync_out, vsync_out to the glyph
//   path; frame_swap pulse, bad_value sticky flag, tile_frame border flag.
// Build option: define TILE_FRAME_EN to generate the tile border ring on tile_frame.
module board_render_ctrl
  import game_2048_pkg::*;
#(
  parameter int BOARD_X  = BOARD_X_DEF,
  parameter int BOARD_Y  = BOARD_Y_DEF,
  parameter int TILE     = TILE_DEF,
  parameter int GAP      = GAP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  logic         video_on,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic [191:0] board_in,
  input  logic         board_valid,
  output logic         board_ready,
  output logic [11:0]  number,
  output logic [9:0]   px_x,
  output logic [9:0]   px_y,
  output logic [9:0]   x_offset,
  output logic [9:0]   y_offset,
  output logic         active_pixel,
  output logic [3:0]   tile_idx,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         frame_swap,
  output logic         bad_value,
  output logic         tile_frame
);

  logic [191:0] pending;
  logic [191:0] shadow;
  logic         pend_full;
  state_t       state;

  logic [1:0] row, col;
  logic       in_tile;
  logic [9:0] x_org, y_org;

  tile_locator #(
    .BOARD_X (BOARD_X),
    .BOARD_Y (BOARD_Y),
    .TILE    (TILE),
    .GAP     (GAP)
  ) u_locator (
    .x       (x),
    .y       (y),
    .row     (row),
    .col     (col),
    .in_tile (in_tile),
    .x_org   (x_org),
    .y_org   (y_org)
  );

  logic [3:0] tile_sel;
  tile_t      cur_val;
  logic       accept;
  logic       swap;
  logic       show_tile;
  logic       val_legal;

  assign tile_sel    = {row, col};
  assign cur_val     = shadow[12*tile_sel +: 12];
  assign board_ready = ~pend_full;
  assign accept      = board_valid & ~pend_full;
  // Swap only at the start of the first non-visible line so a frame never tears.
  assign swap        = pend_full && (x == 10'd0) && (y == 10'(V_ACTIVE));
  assign show_tile   = in_tile && (state == ST_SHOW);
  assign val_legal   = is_legal(cur_val);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending      <= '0;
      shadow       <= '0;
      pend_full    <= 1'b0;
      state        <= ST_EMPTY;
      number       <= '0;
      px_x         <= '0;
      px_y         <= '0;
      x_offset     <= '0;
      y_offset     <= '0;
      active_pixel <= 1'b0;
      tile_idx     <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      frame_swap   <= 1'b0;
      bad_value    <= 1'b0;
    end else begin
      // accept needs pending empty and swap needs it full, so they are exclusive.
      if (accept) begin
        pending   <= board_in;
        pend_full <= 1'b1;
      end else if (swap) begin
        shadow    <= pending;
        pend_full <= 1'b0;
        state     <= ST_SHOW;
      end

      frame_swap   <= swap;
      px_x         <= x;
      px_y         <= y;
      hsync_out    <= hsync_in;
      vsync_out    <= vsync_in;
      number       <= show_tile ? cur_val  : 12'd0;
      x_offset     <= show_tile ? x_org    : 10'd0;
      y_offset     <= show_tile ? y_org    : 10'd0;
      tile_idx     <= show_tile ? tile_sel : 4'd0;
      active_pixel <= video_on && show_tile && val_legal && (cur_val != 12'd0);
      if (in_tile && !val_legal)
        bad_value <= 1'b1;
    end
  end

`ifdef TILE_FRAME_EN
  logic [9:0] loc_x, loc_y;
  logic       ring;

  assign loc_x = x - x_org;
  assign loc_y = y - y_org;
  // Outer 2-pixel ring: local coordinate 0, 1, TILE-2 or TILE-1 on either axis.
  assign ring  = (loc_x < 10'd2) || (loc_x >= 10'(TILE - 2)) ||
                 (loc_y < 10'd2) || (loc_y >= 10'(TILE - 2));

  always_ff @(posedge clk) begin
    if (!rst)
      tile_frame <= 1'b0;
    else
      tile_frame <= video_on && show_tile && ring;
  end
`else
  assign tile_frame = 1'b0;
`endif

endmodule

// File: tb/tb_board_render_ctrl.sv
// Directed bench for board_render_ctrl: reset, snapshot handshake, tile lookup,
// gaps and board edges, illegal values, and reset mid-frame.
module tb_board_render_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   x, y;
  logic         video_on, hsync_in, vsync_in;
  logic [191:0] board_in;
  logic         board_valid;
  logic         board_ready;
  logic [11:0]  number;
  logic [9:0]   px_x, px_y, x_offset, y_offset;
  logic         active_pixel;
  logic [3:0]   tile_idx;
  logic         hsync_out, vsync_out, frame_swap, bad_value, tile_frame;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  board_render_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .y            (y),
    .video_on     (video_on),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .board_in     (board_in),
    .board_valid  (board_valid),
    .board_ready  (board_ready),
    .number       (number),
    .px_x         (px_x),
    .px_y         (px_y),
    .x_offset     (x_offset),
    .y_offset     (y_offset),
    .active_pixel (active_pixel),
    .tile_idx     (tile_idx),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .frame_swap   (frame_swap),
    .bad_value    (bad_value),
    .tile_frame   (tile_frame)
  );

  // Present one pixel, clock it, and sample outputs 1 time unit after the edge.
  task automatic step(input logic [9:0] sx, input logic [9:0] sy);
    x = sx;
    y = sy;
    video_on = (sx < 10'd640) && (sy < 10'd480);
    @(posedge clk);
    #1;
  endtask

  // Hand a board over with one valid cycle, then swap it in at (0,480).
  task automatic load_and_swap(input logic [191:0] b);
    board_in = b;
    board_valid = 1'b1;
    step(10'd600, 10'd470);
    board_valid = 1'b0;
    step(10'd0, 10'd480);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(10'd220, 10'd140);
    step(10'd220, 10'd140);
    n_chk++; if (active_pixel !== 1'b0) $display("FAIL rst_active got %b want 0", active_pixel); else n_pass++;
    n_chk++; if (board_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", board_ready); else n_pass++;
    n_chk++; if (number !== 12'd0) $display("FAIL rst_number got %0d want 0", number); else n_pass++;
    n_chk++; if (px_x !== 10'd0) $display("FAIL rst_px_x got %0d want 0", px_x); else n_pass++;
    n_chk++; if (bad_value !== 1'b0) $display("FAIL rst_bad got %b want 0", bad_value); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_idle_frame;
    logic any_active, any_swap, any_busy;
    any_active = 1'b0;
    any_swap   = 1'b0;
    any_busy   = 1'b0;
    for (int yy = 0; yy < 480; yy += 8) begin
      for (int xx = 0; xx < 640; xx += 8) begin
        step(10'(xx), 10'(yy));
        any_active |= active_pixel;
        any_swap   |= frame_swap;
        any_busy   |= ~board_ready;
      end
    end
    step(10'd0, 10'd480);
    any_swap |= frame_swap;
    n_chk++; if (any_active !== 1'b0) $display("FAIL idle_active got %b want 0", any_active); else n_pass++;
    n_chk++; if (any_swap !== 1'b0) $display("FAIL idle_swap got %b want 0", any_swap); else n_pass++;
    n_chk++; if (any_busy !== 1'b0) $display("FAIL idle_ready_low got %b want 0", any_busy); else n_pass++;
  endtask

  task automatic test_first_board;
    logic [191:0] b;
    b = '0;
    b[12*5 +: 12] = 12'd2048;
    board_in = b;
    board_valid = 1'b1;
    step(10'd0, 10'd300);
    board_valid = 1'b0;
    n_chk++; if (board_ready !== 1'b0) $display("FAIL t2_ready_after_load got %b want 0", board_ready); else n_pass++;
    step(10'd0, 10'd480);
    n_chk++; if (frame_swap !== 1'b1) $display("FAIL t2_swap got %b want 1", frame_swap); else n_pass++;
    n_chk++; if (board_ready !== 1'b1) $display("FAIL t2_ready_after_swap got %b want 1", board_ready); else n_pass++;
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    step(10'd220, 10'd140);
    hsync_in = 1'b0;
    n_chk++; if (frame_swap !== 1'b0) $display("FAIL t2_swap_pulse got %b want 0", frame_swap); else n_pass++;
    n_chk++; if (number !== 12'd2048) $display("FAIL t2_number got %0d want 2048", number); else n_pass++;
    n_chk++; if (x_offset !== 10'd215) $display("FAIL t2_x_offset got %0d want 215", x_offset); else n_pass++;
    n_chk++; if (y_offset !== 10'd135) $display("FAIL t2_y_offset got %0d want 135", y_offset); else n_pass++;
    n_chk++; if (tile_idx !== 4'd5) $display("FAIL t2_tile_idx got %0d want 5", tile_idx); else n_pass++;
    n_chk++; if (active_pixel !== 1'b1) $display("FAIL t2_active got %b want 1", active_pixel); else n_pass++;
    n_chk++; if (px_x !== 10'd220 || px_y !== 10'd140) $display("FAIL t2_px got %0d,%0d want 220,140", px_x, px_y); else n_pass++;
    n_chk++; if (hsync_out !== 1'b1 || vsync_out !== 1'b0) $display("FAIL t2_sync got %b%b want 10", hsync_out, vsync_out); else n_pass++;
  endtask

  task automatic test_gap;
    step(10'd210, 10'd140);
    n_chk++; if (active_pixel !== 1'b0) $display("FAIL t3_gap_active got %b want 0", active_pixel); else n_pass++;
    n_chk++; if (number !== 12'd0) $display("FAIL t3_gap_number got %0d want 0", number); else n_pass++;
    n_chk++; if (tile_idx !== 4'd0 || x_offset !== 10'd0) $display("FAIL t3_gap_idx got %0d/%0d want 0/0", tile_idx, x_offset); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [191:0] b, c;
    b = '0;
    b[12*0 +: 12]  = 12'd2;
    b[12*5 +: 12]  = 12'd4;
    b[12*15 +: 12] = 12'd1024;
    c = '0;
    c[12*5 +: 12]  = 12'd8;
    board_in = b;
    board_valid = 1'b1;
    step(10'd300, 10'd200);
    n_chk++; if (board_ready !== 1'b0) $display("FAIL t4_ready_mid got %b want 0", board_ready); else n_pass++;
    // Third board offered while pending is full: must not be taken.
    board_in = c;
    step(10'd220, 10'd140);
    n_chk++; if (number !== 12'd2048) $display("FAIL t4_old_board got %0d want 2048", number); else n_pass++;
    n_chk++; if (board_ready !== 1'b0) $display("FAIL t4_ready_hold got %b want 0", board_ready); else n_pass++;
    step(10'd110, 10'd30);
    n_chk++; if (number !== 12'd0 || active_pixel !== 1'b0) $display("FAIL t4_old_tile0 got %0d/%b want 0/0", number, active_pixel); else n_pass++;
    step(10'd0, 10'd479);
    board_valid = 1'b0;
    step(10'd0, 10'd480);
    n_chk++; if (frame_swap !== 1'b1) $display("FAIL t4_swap got %b want 1", frame_swap); else n_pass++;
    step(10'd220, 10'd140);
    n_chk++; if (number !== 12'd4) $display("FAIL t4_new_board got %0d want 4", number); else n_pass++;
    n_chk++; if (board_ready !== 1'b1) $display("FAIL t4_ready_after got %b want 1", board_ready); else n_pass++;
    step(10'd110, 10'd30);
    n_chk++; if (number !== 12'd2 || active_pixel !== 1'b1) $display("FAIL t4_tile0 got %0d/%b want 2/1", number, active_pixel); else n_pass++;
    step(10'd534, 10'd454);
    n_chk++; if (number !== 12'd1024 || tile_idx !== 4'd15) $display("FAIL t4_tile15 got %0d/%0d want 1024/15", number, tile_idx); else n_pass++;
    n_chk++; if (x_offset !== 10'd435 || y_offset !== 10'd355) $display("FAIL t4_org15 got %0d,%0d want 435,355", x_offset, y_offset); else n_pass++;
    step(10'd535, 10'd454);
    n_chk++; if (number !== 12'd0 || active_pixel !== 1'b0) $display("FAIL t4_past_edge got %0d/%b want 0/0", number, active_pixel); else n_pass++;
    step(10'd314, 10'd140);
    n_chk++; if (active_pixel !== 1'b1 || x_offset !== 10'd215) $display("FAIL t4_last_col got %b/%0d want 1/215", active_pixel, x_offset); else n_pass++;
    step(10'd315, 10'd140);
    n_chk++; if (active_pixel !== 1'b0) $display("FAIL t4_first_gap got %b want 0", active_pixel); else n_pass++;
    n_chk++; if (bad_value !== 1'b0) $display("FAIL t4_bad_clear got %b want 0", bad_value); else n_pass++;
  endtask

  task automatic test_bad_value;
    logic [191:0] b;
    b = '0;
    b[12*0 +: 12] = 12'd3;
    load_and_swap(b);
    step(10'd300, 10'd20);
    n_chk++; if (bad_value !== 1'b0) $display("FAIL t5_bad_early got %b want 0", bad_value); else n_pass++;
    step(10'd110, 10'd30);
    n_chk++; if (bad_value !== 1'b1) $display("FAIL t5_bad_set got %b want 1", bad_value); else n_pass++;
    n_chk++; if (active_pixel !== 1'b0 || number !== 12'd3) $display("FAIL t5_bad_tile got %b/%0d want 0/3", active_pixel, number); else n_pass++;
    step(10'd220, 10'd140);
    n_chk++; if (bad_value !== 1'b1) $display("FAIL t5_bad_sticky got %b want 1", bad_value); else n_pass++;
    n_chk++; if (active_pixel !== 1'b0) $display("FAIL t5_empty_tile got %b want 0", active_pixel); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    logic [191:0] b;
    logic         exp_frame;
    b = '0;
    b[12*5 +: 12] = 12'd8;
    board_in = b;
    board_valid = 1'b1;
    step(10'd100, 10'd100);
    board_valid = 1'b0;
    rst = 1'b0;
    hsync_in = 1'b1;
    step(10'd220, 10'd140);
    hsync_in = 1'b0;
    n_chk++; if (bad_value !== 1'b0) $display("FAIL t6_bad got %b want 0", bad_value); else n_pass++;
    n_chk++; if (board_ready !== 1'b1) $display("FAIL t6_ready got %b want 1", board_ready); else n_pass++;
    n_chk++; if (number !== 12'd0 || tile_idx !== 4'd0) $display("FAIL t6_number got %0d/%0d want 0/0", number, tile_idx); else n_pass++;
    n_chk++; if (px_x !== 10'd0 || hsync_out !== 1'b0) $display("FAIL t6_px got %0d/%b want 0/0", px_x, hsync_out); else n_pass++;
    rst = 1'b1;
    step(10'd220, 10'd140);
    n_chk++; if (active_pixel !== 1'b0 || number !== 12'd0) $display("FAIL t6_empty got %b/%0d want 0/0", active_pixel, number); else n_pass++;
    step(10'd0, 10'd480);
    n_chk++; if (frame_swap !== 1'b0) $display("FAIL t6_dropped got %b want 0", frame_swap); else n_pass++;
    b = '0;
    b[12*0 +: 12] = 12'd16;
    load_and_swap(b);
`ifdef TILE_FRAME_EN
    exp_frame = 1'b1;
`else
    exp_frame = 1'b0;
`endif
    step(10'd105, 10'd25);
    n_chk++; if (tile_frame !== exp_frame) $display("FAIL t6_frame_ring got %b want %b", tile_frame, exp_frame); else n_pass++;
    n_chk++; if (number !== 12'd16 || active_pixel !== 1'b1) $display("FAIL t6_reload got %0d/%b want 16/1", number, active_pixel); else n_pass++;
    step(10'd107, 10'd27);
    n_chk++; if (tile_frame !== 1'b0) $display("FAIL t6_frame_inner got %b want 0", tile_frame); else n_pass++;
  endtask

  initial begin
    rst         = 1'b0;
    x           = '0;
    y           = '0;
    video_on    = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    board_in    = '0;
    board_valid = 1'b0;
    test_reset();
    test_idle_frame();
    test_first_board();
    test_gap();
    test_back_to_back();
    test_bad_value();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
